reg_file_sync: RTL and testbench
================================

Name: reg_file_sync

Overview:
- Clocked, parametrised register file. Successor to the combinational 16x8 register bank.
- Provides one synchronous write port and two registered read ports, with write-first bypass.
- Includes a hardware clear sequencer that zeroes every entry after reset or on request, and a busy flag.
- Sits between the instruction decoder (addresses, enables) and the ALU operand inputs.

Parameters:
- DATA_W, 8: width of each register and of the data ports.
- ADDR_W, 4: address width. DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0: when 1, entry 0 is hardwired to zero. Writes to it are dropped and reads return 0.

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- re  in  1  read enable for both read ports.
- r_addr_1  in  ADDR_W  read address, port 1.
- r_addr_2  in  ADDR_W  read address, port 2.
- r_data_1  out  DATA_W  registered read data, port 1.
- r_data_2  out  DATA_W  registered read data, port 2.
- r_valid  out  1  r_data_1/2 updated this cycle.
- clr_req  in  1  request a full clear sweep.
- busy  out  1  clear sweep in progress; the bank does not accept accesses.

Behaviour:
- Reset (rst=1 at a clock edge):
  - r_data_1=0, r_data_2=0, r_valid=0.
  - State=CLEAR, ptr=0, busy=1.
  - Array contents are not touched by rst itself; the sweep zeroes them.
- States and transitions:
  - IDLE -> CLEAR on clr_req=1. On that edge ptr=0 and busy=1.
  - CLEAR: each cycle writes 0 to regs[ptr] and increments ptr. At ptr==DEPTH-1 the entry is cleared, busy=0 and state returns to IDLE on the same edge.
  - busy is high for exactly DEPTH cycles after rst deasserts or after the clr_req edge.
- Access while busy:
  - we, re and clr_req are ignored.
  - r_valid=0.
  - r_data_1/2 hold their values.
- rst asserted mid-sweep: the sweep restarts from ptr=0 and takes the full DEPTH cycles again.
- Write (IDLE, we=1): regs[w_addr] <= w_data at the clock edge. With ZERO_REG=1 and w_addr=0 the write is dropped.
- Read (IDLE, re=1): at the edge, r_data_n <= regs[r_addr_n] and r_valid <= 1. Latency is 1 cycle.
- re=0: r_valid=0 and r_data hold their previous values. The outputs never go high-Z.
- Bypass: if we=1, re=1 and r_addr_n==w_addr in the same cycle, r_data_n gets w_data (write-first). Exception: ZERO_REG=1 with address 0 returns 0.
- Both read ports may target the same address; both return the same value.
- clr_req and we together in IDLE: the clear wins, the write is dropped, and the sweep starts.
- clr_req and re together in IDLE: the read completes normally (r_valid=1 next cycle with pre-clear data), and the sweep starts on the same edge.
- Width: all data is DATA_W bits with no extension or truncation. Addresses are always in range because DEPTH=2**ADDR_W.

Test Plan:
1. Reset for 2 cycles, then idle:
   - busy=1 for exactly 16 cycles, then 0.
   - Reading all 16 addresses afterwards returns 0x00 with r_valid=1 one cycle after each re.
2. Write 0x0A to addr 10, then next cycle re with r_addr_1=10, r_addr_2=1:
   - Next cycle r_data_1=0x0A, r_data_2=0x00, r_valid=1.
3. Same cycle we=1, w_addr=5, w_data=0x5C, re=1, r_addr_1=5, r_addr_2=5:
   - Next cycle both r_data=0x5C (bypass).
4. Fill addrs 0..15 with 0xF0+i, pulse clr_req together with we(addr 3, 0x77):
   - busy high 16 cycles.
   - we/re during busy are ignored and r_valid stays 0.
   - Afterwards all entries read 0x00, including addr 3.
5. Assert rst at sweep cycle 7:
   - busy stays 1 and falls exactly 16 cycles after rst deasserts.
   - r_data=0 and r_valid=0 during that time.
6. ZERO_REG=1: write 0xFF to addr 0, then read addr 0 with bypass and without:
   - Both return 0x00.
   - Addr 1 behaves normally.

Source files
------------

// File: rtl/reg_file_sync.sv
// Parametrised clocked register file: one synchronous write port, two registered
// read ports with write-first bypass, and a hardware clear sweep with busy flag.
module reg_file_sync #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr_1,
  input  logic [ADDR_W-1:0] r_addr_2,
  output logic [DATA_W-1:0] r_data_1,
  output logic [DATA_W-1:0] r_data_2,
  output logic              r_valid,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NPORT = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic                busy_reg;
  logic                r_valid_reg;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic [ADDR_W-1:0]   r_addr      [NPORT];
  logic [DATA_W-1:0]   r_data_reg  [NPORT];
  logic [DATA_W-1:0]   r_data_next [NPORT];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_en;

  assign r_addr[0] = r_addr_1;
  assign r_addr[1] = r_addr_2;
  assign rd_en     = (state_reg == IDLE) && re;

  // The sweep shares the single write port; a clear request drops a concurrent write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = w_addr;
    wr_data = w_data;
    if (state_reg == CLEAR) begin
      wr_en   = !rst;
      wr_addr = ptr_reg;
      wr_data = '0;
    end else begin
      wr_en = !rst && we && !clr_req && !((ZERO_REG != 0) && (w_addr == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      regs[wr_addr] <= wr_data;
  end

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd_port
      assign r_data_next[gi] =
          !rd_en                                        ? r_data_reg[gi] :
          ((ZERO_REG != 0) && (r_addr[gi] == '0))       ? '0 :
          (wr_en && (r_addr[gi] == w_addr))             ? w_data :
                                                          regs[r_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (rst)
        r_data_reg[i] <= '0;
      else
        r_data_reg[i] <= r_data_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      ptr_reg     <= '0;
      busy_reg    <= 1'b1;
      r_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          r_valid_reg <= re;
          if (clr_req) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          r_valid_reg <= 1'b0;
          ptr_reg     <= ptr_reg + ADDR_W'(1);
          if (ptr_reg == {ADDR_W{1'b1}}) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= CLEAR;
          ptr_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign r_data_1 = r_data_reg[0];
  assign r_data_2 = r_data_reg[1];
  assign r_valid  = r_valid_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_reg_file_sync.sv
// Testbench for reg_file_sync: drives a plain and a ZERO_REG instance with the
// same stimulus and compares both against an array/countdown reference model.
module tb_reg_file_sync;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, we, re, clr_req;
  logic [ADDR_W-1:0] w_addr, r_addr_1, r_addr_2;
  logic [DATA_W-1:0] w_data;

  logic [DATA_W-1:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic              rv_a, rv_z, busy_a, busy_z;

  reg_file_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_data(w_data),
    .re(re), .r_addr_1(r_addr_1), .r_addr_2(r_addr_2),
    .r_data_1(rd1_a), .r_data_2(rd2_a), .r_valid(rv_a),
    .clr_req(clr_req), .busy(busy_a)
  );

  reg_file_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_data(w_data),
    .re(re), .r_addr_1(r_addr_1), .r_addr_2(r_addr_2),
    .r_data_1(rd1_z), .r_data_2(rd2_z), .r_valid(rv_z),
    .clr_req(clr_req), .busy(busy_z)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model, index 0 = plain bank, index 1 = ZERO_REG bank.
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  int                m_busy_left [2];
  logic [DATA_W-1:0] m_rd1 [2];
  logic [DATA_W-1:0] m_rd2 [2];
  logic              m_rv  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] read_val(input int z, input logic [ADDR_W-1:0] a,
                                                 input logic wr_ok);
    if (z == 1 && a == 0) return '0;
    if (wr_ok && a == w_addr) return w_data;
    return m_mem[z][a];
  endfunction

  task automatic model_step();
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        m_busy_left[z] = DEPTH;
        m_rv[z]  = 1'b0;
        m_rd1[z] = '0;
        m_rd2[z] = '0;
      end else if (m_busy_left[z] > 0) begin
        m_mem[z][DEPTH - m_busy_left[z]] = '0;
        m_busy_left[z]--;
        m_rv[z] = 1'b0;
      end else begin
        logic wr_ok;
        wr_ok   = we && !clr_req;
        m_rv[z] = re;
        if (re) begin
          m_rd1[z] = read_val(z, r_addr_1, wr_ok);
          m_rd2[z] = read_val(z, r_addr_2, wr_ok);
        end
        if (wr_ok && !(z == 1 && w_addr == 0)) m_mem[z][w_addr] = w_data;
        if (clr_req) m_busy_left[z] = DEPTH;
      end
    end
  endtask

  // One clock: update the model from the current inputs, then sample after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("busy_a",  32'(busy_a), 32'(m_busy_left[0] > 0));
    check("busy_z",  32'(busy_z), 32'(m_busy_left[1] > 0));
    check("valid_a", 32'(rv_a),   32'(m_rv[0]));
    check("valid_z", 32'(rv_z),   32'(m_rv[1]));
    check("rd1_a",   32'(rd1_a),  32'(m_rd1[0]));
    check("rd2_a",   32'(rd2_a),  32'(m_rd2[0]));
    check("rd1_z",   32'(rd1_z),  32'(m_rd1[1]));
    check("rd2_z",   32'(rd2_z),  32'(m_rd2[1]));
    $display("cyc=%0d rst=%0b we=%0b wa=%0d wd=%02h re=%0b ra=%0d/%0d clr=%0b | busy=%0b/%0b rv=%0b/%0b rd=%02h,%02h/%02h,%02h",
             cyc, rst, we, w_addr, w_data, re, r_addr_1, r_addr_2, clr_req,
             busy_a, busy_z, rv_a, rv_z, rd1_a, rd2_a, rd1_z, rd2_z);
  endtask

  task automatic set_idle();
    rst = 1'b0; we = 1'b0; re = 1'b0; clr_req = 1'b0;
    w_addr = '0; w_data = '0; r_addr_1 = '0; r_addr_2 = '0;
  endtask

  task automatic do_write(input int a, input int d);
    set_idle();
    we = 1'b1; w_addr = ADDR_W'(a); w_data = DATA_W'(d);
    cycle();
  endtask

  task automatic do_read(input int a1, input int a2);
    set_idle();
    re = 1'b1; r_addr_1 = ADDR_W'(a1); r_addr_2 = ADDR_W'(a2);
    cycle();
  endtask

  task automatic random_inputs();
    we       = 1'($urandom_range(0, 1));
    re       = 1'($urandom_range(0, 1));
    w_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
    w_data   = DATA_W'($urandom_range(0, 255));
    r_addr_1 = ADDR_W'($urandom_range(0, DEPTH - 1));
    r_addr_2 = ($urandom_range(0, 3) == 0) ? w_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
  endtask

  initial begin
    set_idle();
    // Reset for two cycles, then let the power-on sweep run.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    repeat (DEPTH) cycle();
    for (int i = 0; i < DEPTH; i++) do_read(i, DEPTH - 1 - i);

    // Plain write then read on the next cycle.
    do_write(10, 8'h0A);
    do_read(10, 1);

    // Same-cycle write and read to the same address: write-first bypass.
    set_idle();
    we = 1'b1; w_addr = 4'd5; w_data = 8'h5C;
    re = 1'b1; r_addr_1 = 4'd5; r_addr_2 = 4'd5;
    cycle();

    // Fill, then clear together with a write that must be dropped.
    for (int i = 0; i < DEPTH; i++) do_write(i, 8'hF0 + i);
    set_idle();
    clr_req = 1'b1; we = 1'b1; w_addr = 4'd3; w_data = 8'h77;
    cycle();
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      random_inputs();
      clr_req = 1'($urandom_range(0, 1));
      cycle();
    end
    set_idle();
    for (int i = 0; i < DEPTH; i++) do_read(i, i);

    // Reset in the middle of a sweep restarts it.
    for (int i = 0; i < DEPTH; i++) do_write(i, 8'hA0 + i);
    set_idle();
    clr_req = 1'b1;
    cycle();
    set_idle();
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      random_inputs();
      cycle();
    end

    // Address 0 on the ZERO_REG instance, with and without bypass.
    do_write(0, 8'hFF);
    do_read(0, 1);
    set_idle();
    we = 1'b1; w_addr = 4'd0; w_data = 8'hFF;
    re = 1'b1; r_addr_1 = 4'd0; r_addr_2 = 4'd0;
    cycle();
    do_write(1, 8'h3C);
    do_read(1, 0);

    // Clear request together with a read: the read returns pre-clear data.
    set_idle();
    clr_req = 1'b1; re = 1'b1; r_addr_1 = 4'd1; r_addr_2 = 4'd10;
    cycle();
    set_idle();
    repeat (DEPTH) cycle();

    // Randomised traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      clr_req = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
